ram_wait_ctrl: RTL and testbench
================================

Name: ram_wait_ctrl

Overview:
- Word-addressed RAM with a configurable number of wait states.
- Sits directly downstream of the request arbiter: it consumes that block's Ren/Wen/ramaddr/ramstore and returns busy_o/ramload.
- Models a multi-cycle memory so fetch/data arbitration upstream is exercised under real stalls.
- Holds the storage array, an access FSM and a wait-state counter.

Parameters:
- LAT, 2: wait states per access; legal range 1..15.
- AW, 8: word-address bits; storage is 2**AW x 32-bit words.
- BAD_DATA, 32'hBAD1BAD1: read data returned for an out-of-range address.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- Ren  in  1  read request, level; held by requester until busy_o falls.
- Wen  in  1  write request, level; same hold rule; wins over Ren if both are high.
- ramaddr  in  32  byte address; word index = ramaddr[AW+1:2]; bits [1:0] ignored.
- ramstore  in  32  write data; must stay stable while Wen is held.
- busy_o  out  1  high while a request is present and not yet complete.
- ramload  out  32  read data; valid only in the DONE cycle of a read.
- rstate  out  2  FSM state for debug: 0 IDLE, 1 WAIT, 2 DONE.

Behaviour:
- Reset (async, nRST=0): state=IDLE, cnt=0, latched addr/op/data cleared, ramload=0, rstate=0.
  - busy_o follows its combinational equation (IDLE state) and is 0 during reset only if Ren=Wen=0.
  - Storage array is NOT cleared by reset.
- busy_o = (Ren|Wen) & (state!=DONE), combinational.
- ramload = (state==DONE & op_q==READ) ? rdata : 32'h0.
  - rdata = mem[addr_q] if in range, else BAD_DATA.
- In range means ramaddr[31:AW+2]==0.
- IDLE:
  - If Ren|Wen: latch addr_q=ramaddr, op_q=(Wen?WRITE:READ), wdata_q=ramstore, cnt=LAT-1; go to WAIT.
  - Else stay in IDLE.
- WAIT:
  - If Ren=Wen=0: abort to IDLE; no write performed.
  - Else if ramaddr!=addr_q, or the op implied by Wen/Ren != op_q: restart. Re-latch as in IDLE, cnt=LAT-1, stay in WAIT.
  - Else if cnt==0: go to DONE. On that same edge, a write stores wdata_q into mem[addr_q], if in range; out-of-range writes are dropped silently.
  - Else cnt=cnt-1.
- DONE: exactly one cycle with busy_o=0; then unconditionally IDLE.
  - A request still held in the following IDLE cycle is a new access.
- Latency: request first seen in cycle 0 gives busy_o=1 in cycles 0..LAT and DONE (busy_o=0, data valid) in cycle LAT+1.
  - Back-to-back accesses: LAT+2 cycles each.
- Read-after-write to the same address in the next access returns the new data; the write committed before DONE.
- Both Ren and Wen high: treated as a write.
- Reset asserted mid-access: FSM to IDLE immediately; a pending write is lost; array contents otherwise unchanged.
- cnt is 4 bits wide; it never wraps because it is only decremented when nonzero.

Test Plan:
- LAT=2. Wen=1, ramaddr=32'h00000010, ramstore=32'h33333333 held until busy_o=0.
  - busy_o=1 for cycles 0-2; cycle 3 rstate=2, busy_o=0, ramload=0.
  - Then Ren=1 at the same address: DONE in cycle 3 of the read, ramload=32'h33333333.
- Read at 32'h00000013 after the test above: the low bits are ignored, so ramload=32'h33333333.
- Out of range, 32'h56785678:
  - Read returns ramload=32'hBAD1BAD1 in DONE.
  - A write there followed by a read of word index 8'h9E (32'h00000278) shows that word unchanged.
- Abort: Wen=1 at 32'h00000020, data 32'h11111111. Drop Wen in cycle 1 (WAIT).
  - rstate returns to 0 and busy_o=0.
  - A later read of 32'h00000020 returns the prior contents, not 32'h11111111.
- Restart: read 32'h00000010, and change ramaddr to 32'h00000014 in cycle 1.
  - DONE arrives LAT+1 cycles after the change, i.e. cycle 4.
  - ramload=mem[5].
- Reset mid-write: Wen=1 at 32'h00000030, nRST=0 in cycle 1.
  - rstate=0 asynchronously; ramload=0.
  - After release, a read of 32'h00000030 shows no write occurred.

Source files
------------

// File: rtl/ram_wait_ctrl.sv
// ram_wait_ctrl: word-addressed RAM that stalls each access for LAT wait states.
// Requests are level-held; a changed address or op while waiting restarts the access.
module ram_wait_ctrl #(
  parameter int          LAT      = 2,
  parameter int          AW       = 8,
  parameter logic [31:0] BAD_DATA = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic        busy_o,
  output logic [31:0] ramload,
  output logic [1:0]  rstate
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        op_q, op_d;
  logic [31:0] mem [0:(1 << AW) - 1];
  logic        req, restart, latch, commit, in_range;
  logic [AW-1:0] idx;
  assign req      = Ren | Wen;
  assign restart  = (ramaddr != addr_q) || (Wen != op_q);
  assign latch    = req && (state_q == IDLE || (state_q == WAIT && restart));
  assign in_range = addr_q[31:AW+2] == '0;
  assign idx      = addr_q[AW+1:2];
  // write lands on the edge into DONE so a following read sees it
  assign commit   = state_q == WAIT && req && !restart && cnt_q == '0;
  assign busy_o   = req && state_q != DONE;
  assign ramload  = (state_q == DONE && !op_q) ? (in_range ? mem[idx] : BAD_DATA) : '0;
  assign rstate   = state_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    if (latch) begin
      state_d = WAIT;
      cnt_d   = CNT_INIT;
      addr_d  = ramaddr;
      op_d    = Wen;
      wdata_d = ramstore;
    end else if (state_q == WAIT) begin
      state_d = !req ? IDLE : (cnt_q == '0 ? DONE : WAIT);
      cnt_d   = (req && cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
    end
  end
  // storage is deliberately left out of reset; out-of-range writes are dropped
  always_ff @(posedge CLK) begin
    if (commit && op_q && in_range) mem[idx] <= wdata_q;
  end
endmodule

// File: tb/tb_ram_wait_ctrl.sv
// tb_ram_wait_ctrl: directed checks of latency, data, abort, restart and reset behaviour.
module tb_ram_wait_ctrl;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        Ren = 1'b0, Wen = 1'b0;
  logic [31:0] ramaddr = '0, ramstore = '0;
  logic        busy_o;
  logic [31:0] ramload;
  logic [1:0]  rstate;
  int n_cmp = 0, n_err = 0;

  ram_wait_ctrl #(.LAT(2), .AW(8), .BAD_DATA(32'hBAD1BAD1)) dut (
    .CLK(CLK), .nRST(nRST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .busy_o(busy_o), .ramload(ramload), .rstate(rstate)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // drives one access from cycle 0 and returns the first cycle with busy_o low
  task automatic run_access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                            output int done_cyc, output logic [31:0] load, output logic [1:0] st);
    @(posedge CLK); #1;
    Wen = w; Ren = r; ramaddr = a; ramstore = d;
    done_cyc = -1; load = 'x; st = 'x;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (!busy_o) begin
        done_cyc = c; load = ramload; st = rstate;
        break;
      end
    end
    Wen = 0; Ren = 0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (rstate !== 2'd0) begin n_err++; $display("FAIL reset_rstate: got %0d want 0", rstate); end
    n_cmp++; if (ramload !== 32'h0) begin n_err++; $display("FAIL reset_ramload: got %h want 0", ramload); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy_idle: got %b want 0", busy_o); end
    Ren = 1; #1;
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL reset_busy_req: got %b want 1", busy_o); end
    Ren = 0;
    @(posedge CLK); #1; nRST = 1;
  endtask

  task automatic test_preload;
    int dc; logic [31:0] ld; logic [1:0] st;
    logic [31:0] addrs [4] = '{32'h14, 32'h20, 32'h278, 32'h30};
    logic [31:0] datas [4] = '{32'h55555555, 32'hAAAA0020, 32'h9E9E9E9E, 32'h30303030};
    for (int i = 0; i < 4; i++) begin
      run_access(1, 0, addrs[i], datas[i], dc, ld, st);
      n_cmp++; if (dc !== 3) begin n_err++; $display("FAIL preload_done_cycle[%0d]: got %0d want 3", i, dc); end
    end
  endtask

  task automatic test_write_read;
    int dc; logic [31:0] ld; logic [1:0] st;
    run_access(1, 0, 32'h10, 32'h33333333, dc, ld, st);
    n_cmp++; if (dc !== 3) begin n_err++; $display("FAIL wr_done_cycle: got %0d want 3", dc); end
    n_cmp++; if (st !== 2'd2) begin n_err++; $display("FAIL wr_rstate: got %0d want 2", st); end
    n_cmp++; if (ld !== 32'h0) begin n_err++; $display("FAIL wr_ramload: got %h want 0", ld); end
    run_access(0, 1, 32'h10, 32'h0, dc, ld, st);
    n_cmp++; if (dc !== 3) begin n_err++; $display("FAIL rd_done_cycle: got %0d want 3", dc); end
    n_cmp++; if (st !== 2'd2) begin n_err++; $display("FAIL rd_rstate: got %0d want 2", st); end
    n_cmp++; if (ld !== 32'h33333333) begin n_err++; $display("FAIL rd_data: got %h want 33333333", ld); end
  endtask

  task automatic test_low_bits;
    int dc; logic [31:0] ld; logic [1:0] st;
    run_access(0, 1, 32'h13, 32'h0, dc, ld, st);
    n_cmp++; if (ld !== 32'h33333333) begin n_err++; $display("FAIL lowbits_data: got %h want 33333333", ld); end
  endtask

  task automatic test_out_of_range;
    int dc; logic [31:0] ld; logic [1:0] st;
    run_access(0, 1, 32'h56785678, 32'h0, dc, ld, st);
    n_cmp++; if (ld !== 32'hBAD1BAD1) begin n_err++; $display("FAIL oor_read: got %h want bad1bad1", ld); end
    run_access(1, 0, 32'h56785678, 32'hDEADBEEF, dc, ld, st);
    n_cmp++; if (dc !== 3) begin n_err++; $display("FAIL oor_write_done: got %0d want 3", dc); end
    run_access(0, 1, 32'h278, 32'h0, dc, ld, st);
    n_cmp++; if (ld !== 32'h9E9E9E9E) begin n_err++; $display("FAIL oor_alias: got %h want 9e9e9e9e", ld); end
  endtask

  task automatic test_both_high;
    int dc; logic [31:0] ld; logic [1:0] st;
    run_access(1, 1, 32'h40, 32'h77777777, dc, ld, st);
    n_cmp++; if (ld !== 32'h0) begin n_err++; $display("FAIL both_as_write_load: got %h want 0", ld); end
    run_access(0, 1, 32'h40, 32'h0, dc, ld, st);
    n_cmp++; if (ld !== 32'h77777777) begin n_err++; $display("FAIL both_readback: got %h want 77777777", ld); end
  endtask

  task automatic test_abort;
    int dc; logic [31:0] ld; logic [1:0] st;
    @(posedge CLK); #1;
    Wen = 1; ramaddr = 32'h20; ramstore = 32'h11111111;
    @(posedge CLK); #1;
    Wen = 0;
    @(negedge CLK);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    @(posedge CLK); #1;
    n_cmp++; if (rstate !== 2'd0) begin n_err++; $display("FAIL abort_rstate: got %0d want 0", rstate); end
    run_access(0, 1, 32'h20, 32'h0, dc, ld, st);
    n_cmp++; if (ld !== 32'hAAAA0020) begin n_err++; $display("FAIL abort_readback: got %h want aaaa0020", ld); end
  endtask

  task automatic test_restart;
    int dc; logic [31:0] ld;
    @(posedge CLK); #1;
    Ren = 1; ramaddr = 32'h10;
    @(posedge CLK); #1;
    ramaddr = 32'h14;
    dc = -1; ld = 'x;
    for (int c = 1; c < 20; c++) begin
      @(negedge CLK);
      if (!busy_o) begin dc = c; ld = ramload; break; end
    end
    Ren = 0;
    n_cmp++; if (dc !== 4) begin n_err++; $display("FAIL restart_done_cycle: got %0d want 4", dc); end
    n_cmp++; if (ld !== 32'h55555555) begin n_err++; $display("FAIL restart_data: got %h want 55555555", ld); end
  endtask

  task automatic test_reset_mid_write;
    int dc; logic [31:0] ld; logic [1:0] st;
    @(posedge CLK); #1;
    Wen = 1; ramaddr = 32'h30; ramstore = 32'h12345678;
    @(posedge CLK); #1;
    n_cmp++; if (rstate !== 2'd1) begin n_err++; $display("FAIL midrst_pre_rstate: got %0d want 1", rstate); end
    nRST = 0; #1;
    n_cmp++; if (rstate !== 2'd0) begin n_err++; $display("FAIL midrst_rstate: got %0d want 0", rstate); end
    n_cmp++; if (ramload !== 32'h0) begin n_err++; $display("FAIL midrst_ramload: got %h want 0", ramload); end
    Wen = 0;
    repeat (3) @(posedge CLK);
    #1; nRST = 1;
    run_access(0, 1, 32'h30, 32'h0, dc, ld, st);
    n_cmp++; if (ld !== 32'h30303030) begin n_err++; $display("FAIL midrst_readback: got %h want 30303030", ld); end
  endtask

  task automatic test_back_to_back;
    int done_a, done_b, busy4;
    logic [31:0] ld_a, ld_b;
    done_a = -1; done_b = -1; busy4 = -1;
    @(posedge CLK); #1;
    Ren = 1; ramaddr = 32'h10;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (c == 4) busy4 = int'(busy_o);
      if (rstate == 2'd2) begin
        if (done_a < 0) begin done_a = c; ld_a = ramload; end
        else if (done_b < 0) begin done_b = c; ld_b = ramload; end
      end
    end
    Ren = 0;
    n_cmp++; if (done_a !== 3) begin n_err++; $display("FAIL b2b_first_done: got %0d want 3", done_a); end
    n_cmp++; if (done_b !== 7) begin n_err++; $display("FAIL b2b_second_done: got %0d want 7", done_b); end
    n_cmp++; if (busy4 !== 1) begin n_err++; $display("FAIL b2b_busy_new_access: got %0d want 1", busy4); end
    n_cmp++; if (ld_a !== 32'h33333333 || ld_b !== 32'h33333333) begin
      n_err++; $display("FAIL b2b_data: got %h/%h want 33333333", ld_a, ld_b);
    end
  endtask

  initial begin
    test_reset;
    test_preload;
    test_write_read;
    test_low_bits;
    test_out_of_range;
    test_both_high;
    test_abort;
    test_restart;
    test_reset_mid_write;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
